bus_traffic_master: RTL and testbench

//  Active initiator for the simple valid/ready bus (clk, valid, ready, wr_en, addr, wdata, rdata).
//  On a start pulse it runs a write burst of NUM_TXN LFSR words to consecutive addresses.
//  It then reads the same addresses back and checks each rdata against the regenerated LFSR stream.

---
 rtl/bus_traffic_master.sv | 217 +++++++++++++++++++++
 tb/tb_bus_traffic_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_traffic_master.sv
// Active valid/ready bus initiator: writes an LFSR burst, reads it back and counts mismatches.
// Aborts the run if the slave holds ready low for TIMEOUT consecutive request cycles.
module bus_traffic_master #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_TXN   = 16,
    parameter logic [31:0] LFSR_SEED = 32'hACE11234,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              valid,
    input  logic              ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              timeout
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("bus_traffic_master: DATA_W must be 32");
    end
    if ((NUM_TXN < 1) || (64'(NUM_TXN) > (64'(1) << ADDR_W))) begin : g_bad_num_txn
        $error("bus_traffic_master: NUM_TXN must be in 1..2**ADDR_W");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("bus_traffic_master: TIMEOUT must be at least 1");
    end
    if (LFSR_SEED == 32'h0) begin : g_bad_seed
        $error("bus_traffic_master: LFSR_SEED must be nonzero");
    end

    localparam int unsigned       WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TXN - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [DATA_W-1:0] SEED     = DATA_W'(LFSR_SEED);
    localparam logic [DATA_W-1:0] POLY     = DATA_W'(32'h80200003);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

    // Galois step: shift right, fold the taps back in when the dropped bit was 1.
    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] x);
        lfsr_next = (x >> 1) ^ (x[0] ? POLY : '0);
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   lfsr_q, lfsr_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                valid_q, valid_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   first_err_q, first_err_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;

    logic                fire;
    logic                stall;
    logic                active;
    logic [ADDR_W-1:0]   idx_inc;
    logic [DATA_W-1:0]   lfsr_adv;
    logic [WAIT_W-1:0]   wait_inc;

    always_comb begin
        fire     = valid_q && ready;
        stall    = valid_q && !ready;
        active   = (state_q == StWrite) || (state_q == StRead);
        idx_inc  = idx_q + ADDR_W'(1);
        lfsr_adv = lfsr_next(lfsr_q);
        wait_inc = wait_q + WAIT_W'(1);

        state_d     = state_q;
        idx_d       = idx_q;
        base_d      = base_q;
        lfsr_d      = lfsr_q;
        wait_d      = wait_q;
        valid_d     = valid_q;
        wr_en_d     = wr_en_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        done_d      = done_q;
        timeout_d   = timeout_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StWrite;
                    base_d      = base_addr;
                    idx_d       = '0;
                    lfsr_d      = SEED;
                    wait_d      = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    done_d      = 1'b0;
                    timeout_d   = 1'b0;
                    valid_d     = 1'b1;
                    wr_en_d     = 1'b1;
                    addr_d      = base_addr;
                    wdata_d     = SEED;
                end
            end
            StWrite: begin
                if (fire) begin
                    wait_d = '0;
                    if (idx_q == LAST_IDX) begin
                        // Readback restarts the stream from the seed at the base address.
                        state_d = StRead;
                        idx_d   = '0;
                        lfsr_d  = SEED;
                        wr_en_d = 1'b0;
                        addr_d  = base_q;
                        wdata_d = '0;
                    end else begin
                        idx_d   = idx_inc;
                        lfsr_d  = lfsr_adv;
                        addr_d  = base_q + idx_inc;
                        wdata_d = lfsr_adv;
                    end
                end
            end
            StRead: begin
                if (fire) begin
                    wait_d = '0;
                    if (rdata != lfsr_q) begin
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                        // err_cnt never wraps, so zero means no error yet in this run.
                        if (err_cnt_q == 16'd0) begin
                            first_err_d = addr_q;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = StDone;
                        valid_d = 1'b0;
                        addr_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_inc;
                        lfsr_d = lfsr_adv;
                        addr_d = base_q + idx_inc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (active && stall) begin
            wait_d = wait_inc;
            if (wait_inc == WAIT_MAX) begin
                state_d   = StDone;
                wait_d    = '0;
                valid_d   = 1'b0;
                wr_en_d   = 1'b0;
                addr_d    = '0;
                wdata_d   = '0;
                done_d    = 1'b1;
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            base_q      <= '0;
            lfsr_q      <= SEED;
            wait_q      <= '0;
            valid_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            lfsr_q      <= lfsr_d;
            wait_q      <= wait_d;
            valid_q     <= valid_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign valid          = valid_q;
    assign wr_en          = wr_en_q;
    assign addr           = addr_q;
    assign wdata          = wdata_q;
    assign busy           = (state_q == StWrite) || (state_q == StRead);
    assign done           = done_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_bus_traffic_master.sv
// Bench for bus_traffic_master: table-driven runs plus randomized runs against a run-level model,
// with a memory slave whose per-transaction stall counts and read corruption are programmable.
module tb_bus_traffic_master;

    localparam int          NUM  = 4;
    localparam int          TO   = 64;
    localparam logic [31:0] SEED = 32'hACE11234;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic        valid;
    logic        ready = 1'b0;
    logic        wr_en;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata = 32'h0;
    logic        busy;
    logic        done;
    logic [15:0] err_cnt;
    logic [7:0]  first_err_addr;
    logic        timeout;

    always #5 clk = ~clk;

    bus_traffic_master #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .NUM_TXN  (NUM),
        .LFSR_SEED(SEED),
        .TIMEOUT  (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .valid         (valid),
        .ready         (ready),
        .wr_en         (wr_en),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .busy          (busy),
        .done          (done),
        .err_cnt       (err_cnt),
        .first_err_addr(first_err_addr),
        .timeout       (timeout)
    );

    typedef struct packed {
        logic        wr;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] c;
    } hs_t;

    typedef struct packed {
        logic [7:0]  base;
        logic [63:0] stall;   // byte k = ready-low cycles before transaction k is accepted
        logic [3:0]  mask;    // bit i = slave returns 0 for read i
        logic [15:0] e_err;
        logic [7:0]  e_fea;
        logic        e_to;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int txn_k  = 8;
    int wcnt   = 0;

    logic [31:0]     mem [256];
    logic [7:0][7:0] cur_stall = '0;
    logic [3:0]      cur_mask  = '0;
    hs_t             log_q[$];
    hs_t             exp_q[$];
    bit              hold_pend = 1'b0;
    logic [40:0]     hold_val  = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        lfsr_step = x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
    endfunction

    // Slave: present ready/rdata away from the clock edge, log handshakes on the edge.
    always @(negedge clk) begin
        if (hold_pend && valid && !rst) begin
            chk("hold_stable", 128'({wr_en, addr, wdata}), 128'(hold_val));
        end
        hold_pend = 1'b0;
        ready = valid && (txn_k < 8) && (wcnt >= int'(cur_stall[txn_k]));
        if (valid && !wr_en) begin
            if ((txn_k >= NUM) && (txn_k < 8) && cur_mask[txn_k-NUM]) rdata = 32'h0;
            else rdata = mem[addr];
        end else begin
            rdata = 32'h0;
        end
    end

    always @(posedge clk) begin
        if (!rst && valid && ready) begin
            log_q.push_back(hs_t'({wr_en, addr, wdata, 32'(cyc)}));
            if (wr_en) mem[addr] = wdata;
            txn_k++;
            wcnt = 0;
        end else if (!rst && valid) begin
            wcnt++;
            hold_pend = 1'b1;
            hold_val  = {wr_en, addr, wdata};
        end
        cyc++;
    end

    // Whole-run expectation: list of handshakes with cycle numbers, final status and end cycle.
    task automatic model(input logic [7:0] b, input logic [63:0] st, input logic [3:0] m,
                         input int s_cyc, output logic [15:0] e_err, output logic [7:0] e_fea,
                         output logic e_to, output int e_end);
        logic [31:0] lf;
        logic [7:0]  a;
        int          t;
        int          sk;
        exp_q.delete();
        lf = SEED; t = s_cyc + 1; e_err = '0; e_fea = '0; e_to = 1'b0; e_end = 0;
        for (int k = 0; k < 2 * NUM; k++) begin
            if (!e_to) begin
                if (k == NUM) lf = SEED;
                a  = b + 8'(k % NUM);
                sk = int'(st[8*k +: 8]);
                if (sk >= TO) begin
                    e_to  = 1'b1;
                    e_end = t + TO - 1;
                end else begin
                    t = t + sk;
                    exp_q.push_back(hs_t'({k < NUM, a, (k < NUM) ? lf : 32'h0, 32'(t)}));
                    if (k >= NUM && m[k-NUM]) begin
                        e_err++;
                        if (e_err == 16'd1) e_fea = a;
                    end
                    lf    = lfsr_step(lf);
                    e_end = t;
                    t     = t + 1;
                end
            end
        end
    endtask

    task automatic arm_slave(input logic [63:0] st, input logic [3:0] m);
        cur_stall = st; cur_mask = m; txn_k = 0; wcnt = 0;
        log_q.delete();
    endtask

    task automatic cmp_log(input int upto);
        for (int i = 0; i < upto && i < log_q.size() && i < exp_q.size(); i++) begin
            chk("hs_bus", 128'({log_q[i].wr, log_q[i].a, log_q[i].d}),
                128'({exp_q[i].wr, exp_q[i].a, exp_q[i].d}));
            chk("hs_cycle", 128'(log_q[i].c), 128'(exp_q[i].c));
        end
    endtask

    // One full run; mid >= 0 pulses start at that many cycles in if the run is still busy.
    task automatic do_run(input logic [7:0] b, input logic [63:0] st, input logic [3:0] m,
                          input int mid);
        int          n;
        int          s_cyc;
        int          e_end;
        logic [15:0] e_err;
        logic [7:0]  e_fea;
        logic        e_to;
        arm_slave(st, m);
        @(negedge clk);
        s_cyc = cyc; start = 1'b1; base_addr = b;
        @(negedge clk);
        start = 1'b0; base_addr = 8'($urandom);
        n = 0;
        while (!done && n < 2000) begin
            if (n == mid && busy) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        chk("done_seen", 128'(done), 128'(1));
        model(b, st, m, s_cyc, e_err, e_fea, e_to, e_end);
        chk("hs_count", 128'(log_q.size()), 128'(exp_q.size()));
        cmp_log(exp_q.size());
        chk("done_cycle", 128'(cyc - 1), 128'(e_end));
        chk("model_status", 128'({err_cnt, first_err_addr, timeout}), 128'({e_err, e_fea, e_to}));
        chk("idle_after_done", 128'({valid, busy}), 128'(0));
    endtask

    vec_t        vecs[9];
    logic [31:0] words[4];
    int          s_cyc;
    int          n;
    int          e_end;
    logic [15:0] e_err;
    logic [7:0]  e_fea;
    logic        e_to;
    logic [63:0] rst_st;
    logic [3:0]  rm;

    initial begin
        vecs[0] = '{base: 8'h10, stall: 64'h0, mask: 4'h0, e_err: 16'd0, e_fea: 8'h00, e_to: 1'b0};
        vecs[1] = '{base: 8'h10, stall: 64'h0300_0300_0300_0300, mask: 4'h0,
                    e_err: 16'd0, e_fea: 8'h00, e_to: 1'b0};
        vecs[2] = '{base: 8'h10, stall: 64'h0, mask: 4'b0100, e_err: 16'd1, e_fea: 8'h12, e_to: 1'b0};
        vecs[3] = '{base: 8'hFE, stall: 64'h0, mask: 4'h0, e_err: 16'd0, e_fea: 8'h00, e_to: 1'b0};
        vecs[4] = '{base: 8'h20, stall: 64'h0000_0000_0040_0000, mask: 4'h0,
                    e_err: 16'd0, e_fea: 8'h00, e_to: 1'b1};
        vecs[5] = '{base: 8'h20, stall: 64'h0, mask: 4'h0, e_err: 16'd0, e_fea: 8'h00, e_to: 1'b0};
        vecs[6] = '{base: 8'h30, stall: 64'h0000_3F00_0000_0000, mask: 4'h0,
                    e_err: 16'd0, e_fea: 8'h00, e_to: 1'b0};
        vecs[7] = '{base: 8'hFE, stall: 64'h0, mask: 4'b1010, e_err: 16'd2, e_fea: 8'hFF, e_to: 1'b0};
        vecs[8] = '{base: 8'h50, stall: 64'h0000_4000_0000_0000, mask: 4'b0001,
                    e_err: 16'd1, e_fea: 8'h50, e_to: 1'b1};
        // Fourth word follows the XOR rule from the third (2B38448D is odd).
        words = '{32'hACE11234, 32'h5670891A, 32'h2B38448D, 32'h95BC2245};

        rst = 1'b1; start = 1'b0; base_addr = 8'h00;
        #1;
        chk("reset_outputs", 128'({valid, wr_en, addr, wdata, busy, done, err_cnt, first_err_addr,
                                   timeout}), 128'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            do_run(vecs[v].base, vecs[v].stall, vecs[v].mask, -1);
            chk($sformatf("vec%0d_err_cnt", v), 128'(err_cnt), 128'(vecs[v].e_err));
            chk($sformatf("vec%0d_first_err", v), 128'(first_err_addr), 128'(vecs[v].e_fea));
            chk($sformatf("vec%0d_timeout", v), 128'(timeout), 128'(vecs[v].e_to));
            if (v == 0) begin
                for (int i = 0; i < NUM && i < log_q.size(); i++) begin
                    chk($sformatf("seq_word%0d", i), 128'(log_q[i].d), 128'(words[i]));
                end
            end
        end

        // Reset in the middle of READ idx 2, with an ignored start pulse earlier in the run.
        rst_st = 64'h0;
        arm_slave(rst_st, 4'h0);
        @(negedge clk);
        s_cyc = cyc; start = 1'b1; base_addr = 8'h40;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (log_q.size() < NUM + 2 && n < 200) begin
            if (log_q.size() == 2 && busy) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        chk("pre_reset_read2", 128'({valid, wr_en, addr, busy}), 128'({1'b1, 1'b0, 8'h42, 1'b1}));
        model(8'h40, rst_st, 4'h0, s_cyc, e_err, e_fea, e_to, e_end);
        chk("pre_reset_hs_count", 128'(log_q.size()), 128'(NUM + 2));
        cmp_log(NUM + 2);
        #2 rst = 1'b1;
        #1;
        chk("reset_mid_run", 128'({valid, wr_en, addr, wdata, busy, done, err_cnt, first_err_addr,
                                   timeout}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        do_run(8'h40, 64'h0, 4'h0, -1);

        for (int r = 0; r < 30; r++) begin
            rst_st = '0;
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 19) == 0) rst_st[8*k +: 8] = 8'(TO + $urandom_range(0, 3));
                else rst_st[8*k +: 8] = 8'($urandom_range(0, 3));
            end
            rm = 4'($urandom);
            do_run(8'($urandom), rst_st, rm, int'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
